mdu_iter: RTL and testbench
===========================

MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, HI and LO width; legal values 8..64, even.
REQ-002 SHALL have parameter MUL_CYCLES, default 5: multiply latency in cycles; legal values 1..16.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port dh, input, WIDTH: operand 1 (rs).
REQ-006 SHALL have port dl, input, WIDTH: operand 2 (rt).
REQ-007 SHALL have port op, input, 4: operation code; the op is sampled every cycle.
REQ-008 SHALL have port flush, input, 1: aborts the operation in flight.
REQ-009 SHALL have port busy, output, 1: an operation is in flight.
REQ-010 SHALL have port invalid, output, 1: one-cycle pulse when an op is rejected.
REQ-011 SHALL have ports hi and lo, output, WIDTH each: architectural HI and LO registers.

Function
REQ-012 Op codes:
- 0 none; 1 mult; 2 multu; 3 div; 4 divu; 5 mthi; 6 mtlo.
- 7 madd; 8 maddu; 9 msub; 10 msubu.
- 11..15 are illegal.
REQ-013 A start is a legal nonzero op with busy=0 and flush=0. A start in cycle T gives busy=1 in cycles T+1..T+N. HI/LO update on the edge that closes cycle T+N, and busy=0 in cycle T+N+1.
REQ-014 Latency N:
- mult/multu/madd/maddu/msub/msubu: N=MUL_CYCLES.
- div/divu: N=WIDTH, one quotient bit per cycle, restoring algorithm.
- mthi/mtlo: N=0. HI (or LO) takes dh on the next edge and busy stays 0.
REQ-015 Multiplication is signed or unsigned per op. The 2*WIDTH product is split into {hi,lo}. Operands are captured at start and later dh/dl changes are ignored.
REQ-016 madd/msub: {hi,lo} +/- product, modulo 2^(2*WIDTH). The {hi,lo} used is the value at the start edge.
REQ-017 Division: lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend. Signed operands are handled by magnitude conversion, then a sign fix in the final cycle.
REQ-018 Divide by zero: lo = all ones, hi = dividend. Busy still lasts the full N cycles.
REQ-019 Signed MIN / -1: lo = MIN, hi = 0.
REQ-020 A nonzero op with busy=1, or an illegal op, is rejected:
- invalid=1 in the next cycle;
- no state change;
- the in-flight operation is unaffected.
REQ-021 Flush: flush=1 in a cycle with busy=1 causes these effects:
- the operation is discarded;
- hi/lo keep their pre-start values;
- busy=0 in the next cycle.
REQ-022 flush=1 together with any op: the op is ignored and invalid stays 0.
REQ-023 State machine:
- IDLE: a start moves to MUL or DIV. mthi/mtlo stay in IDLE.
- MUL or DIV: the counter counts N-1 down to 0. At 0, commit and return to IDLE. Flush returns to IDLE.
REQ-024 The counter width is clog2(max(WIDTH, MUL_CYCLES)+1). No wrap: the counter is reloaded only on start.

Reset
REQ-025 Asserting rst immediately does all of the following:
- forces IDLE, hi=0, lo=0, busy=0, invalid=0;
- clears the counter and the divider datapath;
- abandons any operation in flight without committing it.
REQ-026 On the first edge after rst deasserts, ops are accepted normally.

Configuration
REQ-027 Macro MDU_MADD_EN:
- Defined: ops 7..10 are implemented per REQ-016.
- Undefined: ops 7..10 are illegal per REQ-020, and no accumulator adder is synthesised.

Structure
REQ-028 Package mdu_pkg SHALL hold the op-code constants, the state encoding (IDLE, MUL, DIV) and a WIDTH-independent clog2 function.
REQ-029 Sub-module div_iter SHALL hold the restoring divider, one bit per cycle. It has a load/step interface and exposes quotient and remainder. Sign handling stays in mdu_iter.

Verification (WIDTH=32, MUL_CYCLES=5)
REQ-030 mult, dh=FFFFFFFF, dl=00000002:
- busy high for 5 cycles;
- then hi=FFFFFFFF, lo=FFFFFFFE.
REQ-031 divu, dh=100, dl=7:
- busy high for 32 cycles;
- then lo=14, hi=2.
REQ-032 div, dh=-7, dl=2: lo=FFFFFFFD, hi=FFFFFFFF.
REQ-033 Divide by zero and MIN/-1 cases:
- div 5/0 -> lo=FFFFFFFF, hi=5;
- div 80000000/FFFFFFFF -> lo=80000000, hi=0.
REQ-034 Mid-operation events:
- mthi 0x1234 then divu issued; mult at cycle 3 of the divu -> invalid pulse, divu result still correct.
- flush at cycle 10 of a divu -> hi=0x1234, busy=0 next cycle.
- rst low during cycle 2 of a mult -> hi=lo=0, busy=0.
REQ-035 With MDU_MADD_EN, start from hi=0, lo=FFFFFFFF, then maddu 1*1 -> hi=1, lo=0. Without the macro, the same op -> invalid pulse and hi/lo unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// ============================================================================
// Module      : mdu_pkg
// Description : Op codes, FSM state encoding and elaboration helpers shared
//               by the iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_iter.sv
// ============================================================================
// Module      : div_iter
// Description : Unsigned restoring divider, one quotient bit per step.
//               quotient/remainder show the result of the step in progress.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;

  logic [WIDTH+1:0] diff;
  logic             fits;
  logic [WIDTH-1:0] quot_step;
  logic [WIDTH:0]   rem_step;

  always_comb begin
    // Trial subtract of the divisor from the partial remainder shifted by one.
    diff      = {rem_q, quot_q[WIDTH-1]} - {2'b00, dvs_q};
    fits      = ~diff[WIDTH+1];
    quot_step = {quot_q[WIDTH-2:0], fits};
    rem_step  = fits ? diff[WIDTH:0] : {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};

    quot_d = quot_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    if (load) begin
      quot_d = dividend;
      rem_d  = '0;
      dvs_d  = divisor;
    end else if (step) begin
      quot_d = quot_step;
      rem_d  = rem_step;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

  assign quotient  = quot_step;
  assign remainder = rem_step[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/mdu_iter.sv
// ============================================================================
// Module      : mdu_iter
// Description : Iterative MIPS-style multiply/divide unit with HI/LO.
//               Macro MDU_MADD_EN enables madd/maddu/msub/msubu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dh,
  input  logic [WIDTH-1:0] dl,
  input  logic [3:0]       op,
  input  logic             flush,
  output logic             busy,
  output logic             invalid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int             CW       = clog2(max_int(WIDTH, MUL_CYCLES) + 1);
  localparam logic [CW-1:0]  MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0]  DIV_LOAD = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             invalid_q, invalid_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
`ifdef MDU_MADD_EN
  logic [1:0]       acc_q, acc_d;
  logic [1:0]       op_acc;
`endif

  logic             op_legal, op_mul, op_div, op_signed;
  logic             start, reject;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             div_load, div_step;
  logic [WIDTH-1:0] div_quot, div_rem;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  logic [2*WIDTH-1:0] a_ext, b_ext, product, mul_res;

  always_comb begin
    op_legal  = 1'b0;
    op_mul    = 1'b0;
    op_div    = 1'b0;
    op_signed = 1'b0;
`ifdef MDU_MADD_EN
    op_acc    = 2'b00;
`endif
    case (op)
      OP_NONE, OP_MTHI, OP_MTLO: op_legal = 1'b1;
      OP_MULT:  begin op_legal = 1'b1; op_mul = 1'b1; op_signed = 1'b1; end
      OP_MULTU: begin op_legal = 1'b1; op_mul = 1'b1; end
      OP_DIV:   begin op_legal = 1'b1; op_div = 1'b1; op_signed = 1'b1; end
      OP_DIVU:  begin op_legal = 1'b1; op_div = 1'b1; end
`ifdef MDU_MADD_EN
      // op_acc = {accumulate, subtract}
      OP_MADD:  begin op_legal = 1'b1; op_mul = 1'b1; op_signed = 1'b1; op_acc = 2'b10; end
      OP_MADDU: begin op_legal = 1'b1; op_mul = 1'b1; op_acc = 2'b10; end
      OP_MSUB:  begin op_legal = 1'b1; op_mul = 1'b1; op_signed = 1'b1; op_acc = 2'b11; end
      OP_MSUBU: begin op_legal = 1'b1; op_mul = 1'b1; op_acc = 2'b11; end
`endif
      default: ;
    endcase
  end

  assign start  = op_legal && (op != OP_NONE) && !busy_q && !flush;
  assign reject = (op != OP_NONE) && !flush && (busy_q || !op_legal);

  // The divider works on magnitudes; signs are reapplied at commit.
  assign dvd_mag = (op_signed && dh[WIDTH-1]) ? -dh : dh;
  assign dvs_mag = (op_signed && dl[WIDTH-1]) ? -dl : dl;

  div_iter #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .step      (div_step),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  assign quot_fix = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -div_quot : div_quot;
  assign rem_fix  = (sgn_q && a_q[WIDTH-1]) ? -div_rem : div_rem;

  assign a_ext   = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
  assign b_ext   = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
  assign product = a_ext * b_ext;

`ifdef MDU_MADD_EN
  always_comb begin
    case (acc_q)
      2'b10:   mul_res = {hi_q, lo_q} + product;
      2'b11:   mul_res = {hi_q, lo_q} - product;
      default: mul_res = product;
    endcase
  end
`else
  assign mul_res = product;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    invalid_d = reject;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
`ifdef MDU_MADD_EN
    acc_d     = acc_q;
`endif
    div_load  = 1'b0;
    div_step  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MTHI) begin
            hi_d = dh;
          end else if (op == OP_MTLO) begin
            lo_d = dh;
          end else begin
            a_d    = dh;
            b_d    = dl;
            sgn_d  = op_signed;
            busy_d = 1'b1;
`ifdef MDU_MADD_EN
            acc_d  = op_acc;
`endif
            if (op_mul) begin
              state_d = ST_MUL;
              cnt_d   = MUL_LOAD;
            end else if (op_div) begin
              state_d  = ST_DIV;
              cnt_d    = DIV_LOAD;
              div_load = 1'b1;
            end
          end
        end
      end

      ST_MUL, ST_DIV: begin
        div_step = (state_q == ST_DIV) && !flush;
        if (flush) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          if (state_q == ST_MUL) begin
            {hi_d, lo_d} = mul_res;
          end else if (b_q == '0) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      invalid_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
`ifdef MDU_MADD_EN
      acc_q     <= 2'b00;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      invalid_q <= invalid_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
`ifdef MDU_MADD_EN
      acc_q     <= acc_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign invalid = invalid_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter.sv
// ============================================================================
// Module      : tb_mdu_iter
// Description : Directed self-checking bench for mdu_iter (WIDTH=32,
//               MUL_CYCLES=5) with a cycle-level arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_iter;

  localparam int W  = 32;
  localparam int MC = 5;

`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  dh = '0;
  logic [W-1:0]  dl = '0;
  logic [3:0]    op = '0;
  logic          flush = 1'b0;
  logic          busy, invalid;
  logic [W-1:0]  hi, lo;

  always #5 clk = ~clk;

  mdu_iter #(
    .WIDTH      (W),
    .MUL_CYCLES (MC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .dh      (dh),
    .dl      (dl),
    .op      (op),
    .flush   (flush),
    .busy    (busy),
    .invalid (invalid),
    .hi      (hi),
    .lo      (lo)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int           m_left = 0;
  logic         m_inv = 1'b0;

  function automatic bit legal(input logic [3:0] o);
    if (o <= 4'd6) return 1'b1;
    if (o <= 4'd10) return MADD;
    return 1'b0;
  endfunction

  function automatic logic [63:0] result(input logic [3:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [63:0] acc);
    longint      sa, sb;
    logic [63:0] ua, ub;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (o)
      4'd1:  return sa * sb;
      4'd2:  return ua * ub;
      4'd7:  return acc + (sa * sb);
      4'd8:  return acc + (ua * ub);
      4'd9:  return acc - (sa * sb);
      4'd10: return acc - (ua * ub);
      4'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(ia % ib), 32'(ia / ib)};
      end
      4'd4: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return acc;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_inv = 1'b0;
    end else begin
      m_inv = 1'b0;
      if (m_left > 0) begin
        if (flush) m_left = 0;
        else begin
          if (op != 0) m_inv = 1'b1;
          m_left--;
          if (m_left == 0) {m_hi, m_lo} = {p_hi, p_lo};
        end
      end else if (!flush && op != 0) begin
        if (!legal(op)) m_inv = 1'b1;
        else if (op == 4'd5) m_hi = dh;
        else if (op == 4'd6) m_lo = dh;
        else begin
          {p_hi, p_lo} = result(op, dh, dl, {m_hi, m_lo});
          m_left = (op == 4'd3 || op == 4'd4) ? W : MC;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_left > 0);
      check("invalid", invalid, m_inv);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic f);
    op = o; dh = a; dl = b; flush = f;
    step();
    op = '0; flush = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      step();
    end
    if (cyc >= 200) check("run_timeout", busy, 64'd0);
  endtask

  task automatic run(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     output int cyc);
    drive(o, a, b, 1'b0);
    wait_idle(cyc);
  endtask

  initial begin
    int cyc;
    #2 rst = 1'b0;
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_invalid", invalid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;

    run(4'd1, 32'hFFFF_FFFF, 32'h2, cyc);
    check("mult_cycles", cyc, 5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);

    run(4'd4, 32'd100, 32'd7, cyc);
    check("divu_cycles", cyc, 32);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    run(4'd3, 32'hFFFF_FFF9, 32'd2, cyc);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    run(4'd3, 32'd5, 32'd0, cyc);
    check("div0_cycles", cyc, 32);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'd5);

    run(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check("minm1_lo", lo, 32'h8000_0000);
    check("minm1_hi", hi, 32'd0);

    run(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h1);

    run(4'd3, 32'd7, 32'hFFFF_FFFE, cyc);
    run(4'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE, cyc);
    run(4'd4, 32'hFFFF_FFFF, 32'd3, cyc);
    run(4'd1, 32'h8000_0000, 32'h8000_0000, cyc);

    // Illegal op in idle, then op alongside flush.
    drive(4'd11, 32'h1, 32'h1, 1'b0);
    check("illegal_inv", invalid, 1);
    step();
    check("illegal_inv_clr", invalid, 0);
    drive(4'd5, 32'hAAAA, 32'h0, 1'b1);
    check("flush_op_inv", invalid, 0);

    // Op offered in the last busy cycle is rejected.
    drive(4'd1, 32'd3, 32'd4, 1'b0);
    repeat (4) step();
    drive(4'd2, 32'd9, 32'd9, 1'b0);
    check("last_cycle_inv", invalid, 1);
    wait_idle(cyc);

    // Rejected mult mid-divide.
    drive(4'd5, 32'h1234, 32'h0, 1'b0);
    drive(4'd4, 32'd100, 32'd7, 1'b0);
    repeat (2) step();
    drive(4'd1, 32'd3, 32'd4, 1'b0);
    check("mid_inv", invalid, 1);
    check("mid_busy", busy, 1);
    wait_idle(cyc);
    check("mid_lo", lo, 32'd14);
    check("mid_hi", hi, 32'd2);

    // Flush at cycle 10 of a divide.
    drive(4'd5, 32'h1234, 32'h0, 1'b0);
    drive(4'd6, 32'h55, 32'h0, 1'b0);
    drive(4'd4, 32'd100, 32'd7, 1'b0);
    repeat (9) step();
    drive(4'd0, 32'h0, 32'h0, 1'b1);
    check("flush_busy", busy, 0);
    check("flush_hi", hi, 32'h1234);
    check("flush_lo", lo, 32'h55);

    // Reset during cycle 2 of a mult, then resume.
    drive(4'd1, 32'd3, 32'd4, 1'b0);
    step();
    #2 rst = 1'b0;
    #1;
    check("mrst_hi", hi, 0);
    check("mrst_lo", lo, 0);
    check("mrst_busy", busy, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    step();
    run(4'd2, 32'd3, 32'd4, cyc);
    check("post_rst_lo", lo, 32'd12);

    // Accumulate case.
    drive(4'd6, 32'hFFFF_FFFF, 32'h0, 1'b0);
    drive(4'd5, 32'h0, 32'h0, 1'b0);
`ifdef MDU_MADD_EN
    run(4'd8, 32'd1, 32'd1, cyc);
    check("maddu_hi", hi, 32'd1);
    check("maddu_lo", lo, 32'd0);
    run(4'd9, 32'hFFFF_FFFF, 32'd3, cyc);
    run(4'd10, 32'd7, 32'd9, cyc);
    run(4'd7, 32'hFFFF_FFFE, 32'd5, cyc);
`else
    drive(4'd8, 32'd1, 32'd1, 1'b0);
    check("maddu_inv", invalid, 1);
    check("maddu_hi", hi, 32'd0);
    check("maddu_lo", lo, 32'hFFFF_FFFF);
`endif

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
